// File: rtl/pipe_pkg.sv
// Shared types and constants for handshaked pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register with load-enable and synchronous clear to RESET_DATA.
module pipe_skid_entry #(
    parameter int                DATA_W     = 128,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // NOTE: the payload register is reset too, so a flushed or reset stage
    // presents RESET_DATA (e.g. a NOP) instead of stale contents.
    // NOTE: non-blocking assignment keeps register updates race-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_DATA;
        end else if (clear) begin
            q <= RESET_DATA;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline stage with a 2-entry skid buffer and registered o_ready.
// Optional stall counter enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 128,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    skid_state_t       state, next_state;
    logic              in_fire, out_fire;
    logic              main_load, main_clear, skid_load, skid_clear;
    logic [DATA_W-1:0] main_d, skid_q;

    assign o_valid  = (state == BUSY) || (state == FULL);
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = i_data;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state = BUSY;
                    main_load  = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    next_state = FULL;
                    skid_load  = 1'b1;
                end else if (out_fire) begin
                    next_state = EMPTY;
                    main_clear = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    next_state = BUSY;
                    main_load  = 1'b1;
                    main_d     = skid_q;
                    skid_clear = 1'b1;
                end
            end
            default: begin
                next_state = EMPTY;
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end
        endcase
        // Flush wins: an accepted input is dropped, a completed output stands.
        if (i_flush) begin
            next_state = EMPTY;
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end
    end

    // o_ready is registered from next_state, so i_ready never reaches it combinationally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= EMPTY;
            o_ready <= 1'b1;
        end else begin
            state   <= next_state;
            o_ready <= (next_state != FULL);
        end
    end

    pipe_skid_entry #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_main (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (o_data)
    );

    pipe_skid_entry #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_skid (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (i_data),
        .q     (skid_q)
    );

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating; flush deliberately leaves it alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (o_valid && !i_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule
